// File: rtl/normalize_seq_ctrl.sv
// Iterative mantissa normaliser: shifts left one bit per cycle until the MSB is set,
// then reports the normalised mantissa, shift count and floored exponent.
module normalize_seq_ctrl #(
    parameter int unsigned WIDTH = 49,
    parameter int unsigned SH_W  = 9,
    parameter int unsigned EXP_W = 9
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] mant_in,
    input  logic [EXP_W-1:0] exp_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] mant_out,
    output logic [SH_W-1:0]  shamt,
    output logic [EXP_W-1:0] exp_out,
    output logic             zero,
    output logic             underflow
);

    localparam int unsigned CMP_W = (SH_W > EXP_W) ? SH_W : EXP_W;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] work_q,  work_d;
    logic [SH_W-1:0]  cnt_q,   cnt_d;
    logic [EXP_W-1:0] exp_q,   exp_d;
    logic             busy_q,  busy_d;
    logic             done_q,  done_d;
    logic [WIDTH-1:0] mant_q,  mant_d;
    logic [SH_W-1:0]  shamt_q, shamt_d;
    logic [EXP_W-1:0] expo_q,  expo_d;
    logic             zero_q,  zero_d;
    logic             unf_q,   unf_d;

    // Next-state and result computation; every register holds unless assigned.
    always_comb begin
        state_d = state_q;
        work_d  = work_q;
        cnt_d   = cnt_q;
        exp_d   = exp_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        mant_d  = mant_q;
        shamt_d = shamt_q;
        expo_d  = expo_q;
        zero_d  = zero_q;
        unf_d   = unf_q;

        case (state_q)
            IDLE: begin
                busy_d = 1'b0;
                if (start) begin
                    zero_d = 1'b0;
                    unf_d  = 1'b0;
                    busy_d = 1'b1;
                    if (mant_in == '0) begin
                        zero_d  = 1'b1;
                        mant_d  = '0;
                        shamt_d = '0;
                        expo_d  = exp_in;
                        done_d  = 1'b1;
                        state_d = DONE;
                    end else begin
                        work_d  = mant_in;
                        cnt_d   = '0;
                        exp_d   = exp_in;
                        state_d = SHIFT;
                    end
                end
            end
            SHIFT: begin
                if (work_q[WIDTH-1]) begin
                    mant_d  = work_q;
                    shamt_d = cnt_q;
                    done_d  = 1'b1;
                    state_d = DONE;
                    // Exponent floors at zero when more shifts were needed than it can absorb.
                    if (CMP_W'(cnt_q) > CMP_W'(exp_q)) begin
                        expo_d = '0;
                        unf_d  = 1'b1;
                    end else begin
                        expo_d = exp_q - EXP_W'(cnt_q);
                        unf_d  = 1'b0;
                    end
                end else begin
                    work_d = {work_q[WIDTH-2:0], 1'b0};
                    cnt_d  = cnt_q + SH_W'(1);
                end
            end
            DONE: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            work_q  <= '0;
            cnt_q   <= '0;
            exp_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            mant_q  <= '0;
            shamt_q <= '0;
            expo_q  <= '0;
            zero_q  <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            work_q  <= work_d;
            cnt_q   <= cnt_d;
            exp_q   <= exp_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            mant_q  <= mant_d;
            shamt_q <= shamt_d;
            expo_q  <= expo_d;
            zero_q  <= zero_d;
            unf_q   <= unf_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign mant_out  = mant_q;
    assign shamt     = shamt_q;
    assign exp_out   = expo_q;
    assign zero      = zero_q;
    assign underflow = unf_q;

endmodule

// File: tb/tb_normalize_seq_ctrl.sv
// Self-checking bench for normalize_seq_ctrl: directed cases plus randomized jobs
// against a leading-zero-count reference model.
module tb_normalize_seq_ctrl;

    localparam int unsigned W  = 49;
    localparam int unsigned SW = 9;
    localparam int unsigned EW = 9;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [W-1:0]  mant_in = '0;
    logic [EW-1:0] exp_in = '0;
    logic          busy, done, zero, underflow;
    logic [W-1:0]  mant_out;
    logic [SW-1:0] shamt;
    logic [EW-1:0] exp_out;

    int checks = 0;
    int errors = 0;

    normalize_seq_ctrl #(.WIDTH(W), .SH_W(SW), .EXP_W(EW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .mant_in(mant_in), .exp_in(exp_in),
        .busy(busy), .done(done), .mant_out(mant_out), .shamt(shamt),
        .exp_out(exp_out), .zero(zero), .underflow(underflow)
    );

    always #5 clk = ~clk;

    // Reference: count leading zeros arithmetically, shift once, floor the exponent.
    function automatic void model(input logic [W-1:0] m, input logic [EW-1:0] e,
                                  output logic [W-1:0] mo, output int sh,
                                  output logic [EW-1:0] eo, output logic z,
                                  output logic uf, output int lat);
        int p;
        p = -1;
        for (int i = 0; i < int'(W); i++) if (m[i]) p = i;
        if (p < 0) begin
            mo = '0; sh = 0; eo = e; z = 1'b1; uf = 1'b0; lat = 0;
        end else begin
            sh = int'(W) - 1 - p;
            mo = m << sh;
            z  = 1'b0;
            uf = (sh > int'(e));
            eo = uf ? '0 : EW'(int'(e) - sh);
            lat = 1 + sh;
        end
    endfunction

    // Issue one job from IDLE; lat counts cycles after the accepting edge until done.
    task automatic do_job(input logic [W-1:0] m, input logic [EW-1:0] e,
                          output int lat, output int npulse);
        int guard;
        guard = 0;
        while (busy === 1'b1 && guard < 200) begin
            @(posedge clk); #1; guard++;
        end
        start = 1'b1; mant_in = m; exp_in = e;
        @(posedge clk); #1;
        start = 1'b0; mant_in = W'({$urandom(), $urandom()}); exp_in = EW'($urandom());
        lat = -1; npulse = 0;
        for (int n = 0; n < 200; n++) begin
            if (done === 1'b1) begin
                npulse++;
                if (lat < 0) lat = n;
            end
            if (lat >= 0 && n >= lat + 2) break;
            @(posedge clk); #1;
        end
    endtask

    task automatic check_job(input string name, input logic [W-1:0] m, input logic [EW-1:0] e,
                             input int lat, input int npulse);
        logic [W-1:0] mo; logic [EW-1:0] eo; logic z, uf; int sh, el;
        model(m, e, mo, sh, eo, z, uf, el);
        checks++; if (lat != el || npulse != 1) begin errors++;
            $display("FAIL %s latency: got %0d (pulses %0d) expected %0d (pulses 1) m=%h", name, lat, npulse, el, m); end
        checks++; if (mant_out !== mo) begin errors++;
            $display("FAIL %s mant_out: got %h expected %h", name, mant_out, mo); end
        checks++; if (shamt !== SW'(sh)) begin errors++;
            $display("FAIL %s shamt: got %0d expected %0d", name, shamt, sh); end
        checks++; if (exp_out !== eo) begin errors++;
            $display("FAIL %s exp_out: got %0d expected %0d", name, exp_out, eo); end
        checks++; if ({zero, underflow} !== {z, uf}) begin errors++;
            $display("FAIL %s zero/underflow: got %b%b expected %b%b", name, zero, underflow, z, uf); end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if ({busy, done, zero, underflow} !== 4'b0) begin errors++;
            $display("FAIL reset_flags: got %b expected 0000", {busy, done, zero, underflow}); end
        checks++; if (mant_out !== '0 || shamt !== '0 || exp_out !== '0) begin errors++;
            $display("FAIL reset_data: got %h/%0d/%0d expected 0/0/0", mant_out, shamt, exp_out); end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_directed();
        logic [W-1:0]  m_tab [4];
        logic [EW-1:0] e_tab [4];
        int lat, np;
        m_tab[0] = 49'h1_0000_0000_0000; e_tab[0] = 9'd100;
        m_tab[1] = 49'h1;                e_tab[1] = 9'd127;
        m_tab[2] = 49'h0;                e_tab[2] = 9'd5;
        m_tab[3] = 49'h0_8000_0000_0000; e_tab[3] = 9'd0;
        for (int i = 0; i < 4; i++) begin
            do_job(m_tab[i], e_tab[i], lat, np);
            check_job($sformatf("directed%0d", i), m_tab[i], e_tab[i], lat, np);
        end
    endtask

    task automatic test_random();
        logic [W-1:0] m; logic [EW-1:0] e; int lat, np;
        for (int i = 0; i < 40; i++) begin
            m = W'({$urandom(), $urandom()}) >> $urandom_range(0, W - 1);
            if ($urandom_range(0, 9) == 0) m = '0;
            e = ($urandom_range(0, 9) < 3) ? EW'($urandom_range(0, 20)) : EW'($urandom_range(0, 511));
            do_job(m, e, lat, np);
            check_job($sformatf("random%0d", i), m, e, lat, np);
        end
    endtask

    // A start pulse during a long SHIFT must neither restart nor queue a job.
    task automatic test_busy_start();
        int lat, np, n;
        logic [W-1:0] m;
        m = 49'h3;
        start = 1'b1; mant_in = m; exp_in = 9'd60;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        start = 1'b1; mant_in = 49'h1_0000_0000_0000; exp_in = 9'd3;
        @(posedge clk); #1;
        start = 1'b0;
        lat = -1; np = 0;
        for (n = 6; n < 150; n++) begin
            if (done === 1'b1) begin np++; if (lat < 0) lat = n; end
            @(posedge clk); #1;
        end
        check_job("busy_start", m, 9'd60, lat, np);
    endtask

    // start held during the DONE cycle is dropped; the block returns to IDLE.
    task automatic test_done_start();
        int n;
        start = 1'b1; mant_in = '0; exp_in = 9'd9;
        @(posedge clk); #1;
        checks++; if (done !== 1'b1) begin errors++;
            $display("FAIL done_start_pulse: got done=%b expected 1", done); end
        mant_in = 49'h1;
        @(posedge clk); #1;
        start = 1'b0;
        checks++; if (busy !== 1'b0) begin errors++;
            $display("FAIL done_start_ignored: got busy=%b expected 0", busy); end
        n = 0;
        repeat (60) begin @(posedge clk); #1; if (done === 1'b1) n++; end
        checks++; if (n != 0) begin errors++;
            $display("FAIL done_start_spurious: got %0d done pulses expected 0", n); end
    endtask

    // Flags from the previous job clear as soon as a new start is accepted.
    task automatic test_flag_clear();
        int lat, np;
        do_job(49'h0, 9'd1, lat, np);
        start = 1'b1; mant_in = 49'h1; exp_in = 9'd0;
        @(posedge clk); #1;
        start = 1'b0;
        checks++; if (zero !== 1'b0 || busy !== 1'b1) begin errors++;
            $display("FAIL zero_clear: got zero=%b busy=%b expected 0/1", zero, busy); end
        repeat (60) @(posedge clk);
        #1;
        checks++; if (underflow !== 1'b1) begin errors++;
            $display("FAIL underflow_set: got %b expected 1", underflow); end
        start = 1'b1; mant_in = 49'h1; exp_in = 9'd200;
        @(posedge clk); #1;
        start = 1'b0;
        checks++; if (underflow !== 1'b0) begin errors++;
            $display("FAIL underflow_clear: got %b expected 0", underflow); end
        repeat (60) @(posedge clk);
        #1;
    endtask

    task automatic test_reset_mid();
        int n, lat, np;
        start = 1'b1; mant_in = 49'h1; exp_in = 9'd127;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if ({busy, done, zero, underflow} !== 4'b0 || mant_out !== '0 ||
                      shamt !== '0 || exp_out !== '0) begin errors++;
            $display("FAIL reset_mid: got busy=%b done=%b mant=%h sh=%0d exp=%0d expected all 0",
                     busy, done, mant_out, shamt, exp_out); end
        n = 0;
        repeat (4) begin @(posedge clk); #1; if (done === 1'b1) n++; end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (50) begin @(posedge clk); #1; if (done === 1'b1) n++; end
        checks++; if (n != 0 || busy !== 1'b0) begin errors++;
            $display("FAIL reset_mid_abort: got %0d done pulses busy=%b expected 0/0", n, busy); end
        do_job(49'h1_0000_0000_0000, 9'd100, lat, np);
        check_job("after_reset", 49'h1_0000_0000_0000, 9'd100, lat, np);
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_busy_start();
        test_done_start();
        test_flag_clear();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
